// File: rtl/whirlpool_mu_inverse_packer.sv
`default_nettype none
// ============================================================================
//  Module   : whirlpool_mu_inverse_packer
//  Function : Collects an N x N Whirlpool byte state over several input beats,
//             in row-major or column-major order, and presents it as one flat
//             vector with valid/ready handshakes on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module whirlpool_mu_inverse_packer #(
    parameter int N          = 8,
    parameter int BEAT_BYTES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [0:BEAT_BYTES*8-1]     in_data,
    input  logic                        in_col_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [0:N*N*8-1]            out_A
);

    localparam int c_BEATS = (N * N) / BEAT_BYTES;
    localparam int c_CW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_BEATS - 1);

    generate
        if ((N * N) % BEAT_BYTES != 0) begin : g_bad_beat_bytes
            $error("BEAT_BYTES must divide N*N");
        end
    endgenerate

    logic [c_CW-1:0]    r_cnt;
    logic               r_mode;
    logic [0:N*N*8-1]   r_collect;
    logic [0:N*N*8-1]   r_out_a;
    logic               r_out_valid;

    logic               w_mode;
    logic               w_last;
    logic               w_accept;
    logic [0:N*N*8-1]   w_merged;

    // Flat matrix index of stream byte k under the selected fill order.
    function automatic int f_pos(input int k, input logic col);
        return col ? ((k % N) * N + (k / N)) : k;
    endfunction

    assign w_last   = (r_cnt == c_LAST);
    // Only the final beat can stall on a held output; clear blocks acceptance.
    assign in_ready = !clear && !(w_last && r_out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_mode   = (r_cnt == '0) ? in_col_mode : r_mode;

    // Collect buffer with the current beat merged in, so the final beat can
    // be copied straight to the output register on its own handshake edge.
    always_comb begin
        w_merged = r_collect;
        for (int b = 0; b < BEAT_BYTES; b++) begin
            w_merged[8*f_pos(int'(r_cnt) * BEAT_BYTES + b, w_mode) +: 8] = in_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_collect   <= '0;
            r_out_a     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (clear) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_collect <= w_merged;
                r_cnt     <= w_last ? '0 : r_cnt + 1'b1;
                if (r_cnt == '0) begin
                    r_mode <= in_col_mode;
                end
            end

            if (w_accept && w_last) begin
                r_out_a     <= w_merged;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_A     = r_out_a;

endmodule
`default_nettype wire

// File: tb/tb_whirlpool_mu_inverse_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_whirlpool_mu_inverse_packer
//  Function : Randomised self-checking bench with a matrix-level reference
//             model for the 8x8/8-byte packer and a 64-byte-beat instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_whirlpool_mu_inverse_packer;

    logic           clk = 1'b0;
    logic           reset;
    logic           clear;
    logic           in_valid;
    logic           in_ready;
    logic [0:63]    in_data;
    logic           in_col_mode;
    logic           out_valid;
    logic           out_ready;
    logic [0:511]   out_A;

    logic           in_valid64;
    logic           in_ready64;
    logic [0:511]   in_data64;
    logic           out_valid64;
    logic [0:511]   out_A64;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: raw stream bytes of the block in flight, expected output
    byte unsigned   m_stream [64];
    int             m_cnt;
    bit             m_mode;
    bit             m_valid;
    logic [0:511]   m_out;

    always #5 clk = ~clk;

    whirlpool_mu_inverse_packer #(.N(8), .BEAT_BYTES(8)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_col_mode (in_col_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_A       (out_A)
    );

    whirlpool_mu_inverse_packer #(.N(8), .BEAT_BYTES(64)) u_dut64 (
        .clk         (clk),
        .reset       (reset),
        .clear       (1'b0),
        .in_valid    (in_valid64),
        .in_ready    (in_ready64),
        .in_data     (in_data64),
        .in_col_mode (1'b0),
        .out_valid   (out_valid64),
        .out_ready   (1'b1),
        .out_A       (out_A64)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Place stream byte k at matrix element (i,j) by the fill-order rule.
    function automatic logic [0:511] build_matrix(input bit col);
        logic [0:511] a;
        int i, j;
        a = '0;
        for (int k = 0; k < 64; k++) begin
            i = col ? (k % 8) : (k / 8);
            j = col ? (k / 8) : (k % 8);
            a[8*(i*8+j) +: 8] = m_stream[k];
        end
        return a;
    endfunction

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_valid64 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_cnt = 0; m_mode = 1'b0; m_valid = 1'b0; m_out = '0;
        #1;
        check("rst_out_valid", 512'(out_valid), 512'(0));
        check("rst_out_A", out_A, '0);
        check("rst_in_ready", 512'(in_ready), 512'(1));
    endtask

    // One clock cycle on the 8-byte instance, checked against the model.
    task automatic cyc(input bit v, input logic [0:63] d, input bit cm, input bit ordy, input bit clr);
        bit exp_rdy, acc;
        in_valid = v; in_data = d; in_col_mode = cm; out_ready = ordy; clear = clr;
        #1;
        exp_rdy = !clr && !(m_cnt == 7 && m_valid && !ordy);
        check("in_ready", 512'(in_ready), 512'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk); #1;
        if (clr) begin
            m_cnt = 0;
            if (ordy) m_valid = 1'b0;
        end else if (acc) begin
            if (m_cnt == 0) m_mode = cm;
            for (int b = 0; b < 8; b++) m_stream[m_cnt*8+b] = d[8*b +: 8];
            if (m_cnt == 7) begin
                m_out = build_matrix(m_mode);
                m_valid = 1'b1;
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (ordy) m_valid = 1'b0;
            end
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        check("out_valid", 512'(out_valid), 512'(m_valid));
        check("out_A", out_A, m_out);
    endtask

    function automatic logic [0:63] rand64();
        return {$urandom, $urandom};
    endfunction

    logic [0:511] blk1;
    logic [0:63]  beat;
    logic [0:7]   byt;

    initial begin
        in_data = '0; in_col_mode = 1'b0; out_ready = 1'b1; in_data64 = '0;
        do_reset();

        // Row-major: beat r carries bytes 8'h(r,b)
        for (int r = 0; r < 8; r++) begin
            for (int b = 0; b < 8; b++) beat[8*b +: 8] = 8'((r << 4) | b);
            cyc(1, beat, 0, 1, 0);
        end
        blk1 = out_A;
        byt = out_A[0:7];
        check("row_first_byte", 512'(byt), 512'(8'h00));
        byt = out_A[504:511];
        check("row_last_byte", 512'(byt), 512'(8'h77));

        // Column-major: beat c carries bytes 8'h(b,c); later mode bits are noise
        for (int c = 0; c < 8; c++) begin
            for (int b = 0; b < 8; b++) beat[8*b +: 8] = 8'((b << 4) | c);
            cyc(1, beat, (c == 0) ? 1'b1 : 1'($urandom), 1, 0);
        end
        check("col_equals_row", out_A, blk1);

        // Output held: beats 0..6 go in, final beat stalls until out_ready
        for (int r = 0; r < 7; r++) cyc(1, rand64(), 1'($urandom), 0, 0);
        beat = rand64();
        for (int s = 0; s < 3; s++) cyc(1, beat, 0, 0, 0);
        check("held_A", out_A, blk1);
        cyc(1, beat, 0, 1, 0);
        check("b2b_valid", 512'(out_valid), 512'(1));
        cyc(0, '0, 0, 1, 0);

        // Clear mid-block with a beat presented
        for (int r = 0; r < 3; r++) cyc(1, rand64(), 0, 1, 0);
        cyc(1, rand64(), 0, 1, 1);
        for (int r = 0; r < 8; r++) cyc(1, rand64(), 1'($urandom), 1, 0);
        cyc(0, '0, 0, 1, 0);

        // Reset mid-block while output is held valid
        for (int r = 0; r < 8; r++) cyc(1, rand64(), 0, 1, 0);
        for (int r = 0; r < 5; r++) cyc(1, rand64(), 0, 0, 0);
        do_reset();
        for (int r = 0; r < 8; r++) cyc(1, rand64(), 1'($urandom), 1, 0);

        // Random traffic
        for (int t = 0; t < 400; t++)
            cyc(1'($urandom_range(0, 3) != 0), rand64(), 1'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));

        // 64-byte beats: every beat completes a block
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            logic [0:511] w;
            for (int q = 0; q < 16; q++) w[32*q +: 32] = $urandom;
            in_valid64 = 1'b1; in_data64 = w;
            #1;
            check("in_ready64", 512'(in_ready64), 512'(1));
            @(posedge clk); #1;
            check("out_valid64", 512'(out_valid64), 512'(1));
            check("out_A64", out_A64, w);
        end
        in_valid64 = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
